// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin data memory arbiter with read return routing
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  output logic                m0_ready,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_we,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  output logic                m1_ready,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_we,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_we,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int WE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_t;

  owner_t           owner, owner_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gnt0, gnt1;
  logic             rv_pend, rv_port;
  logic             burst_left;

  assign burst_left = (cnt < CNT_MAX);

  // Owner, burst counter and pending read-return tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner   <= IDLE;
      cnt     <= '0;
      rv_pend <= 1'b0;
      rv_port <= 1'b0;
    end else begin
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      rv_pend <= mem_re;
      rv_port <= gnt1;
    end
  end

  // Grant decision and next owner/count; contention favours the owner until its burst is spent
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_nxt = IDLE;
    cnt_nxt   = '0;
    if (m0_valid && !m1_valid) begin
      gnt0 = 1'b1;
    end else if (m1_valid && !m0_valid) begin
      gnt1 = 1'b1;
    end else if (m0_valid && m1_valid) begin
      case (owner)
        OWN0:    if (burst_left) gnt0 = 1'b1; else gnt1 = 1'b1;
        OWN1:    if (burst_left) gnt1 = 1'b1; else gnt0 = 1'b1;
        default: gnt0 = 1'b1;
      endcase
    end
    if (gnt0) begin
      owner_nxt = OWN0;
      cnt_nxt   = (owner == OWN0) ? (burst_left ? cnt + CNT_ONE : CNT_MAX) : CNT_ONE;
    end else if (gnt1) begin
      owner_nxt = OWN1;
      cnt_nxt   = (owner == OWN1) ? (burst_left ? cnt + CNT_ONE : CNT_MAX) : CNT_ONE;
    end
  end

  // Memory request mux; idle bus is driven to zero
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    mem_re    = 1'b0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
      mem_re    = (m0_we == {WE_W{1'b0}});
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
      mem_re    = (m1_we == {WE_W{1'b0}});
    end
  end

  assign m0_ready  = gnt0;
  assign m1_ready  = gnt1;
  assign m0_rvalid = rv_pend & ~rv_port;
  assign m1_rvalid = rv_pend & rv_port;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter at MAX_BURST 4 and 1
module tb_dmem_arbiter;

  typedef struct {
    int          port;
    logic [31:0] data;
  } rd_exp_t;

  logic        clk;
  logic        reset;
  logic        mv   [2][2];
  logic [31:0] ma   [2][2];
  logic [31:0] mwd  [2][2];
  logic [3:0]  mwe  [2][2];
  logic        rdy  [2][2];
  logic        rv   [2][2];
  logic [31:0] rd   [2][2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [3:0]  mem_we    [2];
  logic        mem_re    [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] ref_mem [2][256];
  rd_exp_t     sbq [$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp4 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .m0_valid(mv[0][0]), .m0_ready(rdy[0][0]), .m0_addr(ma[0][0]), .m0_wdata(mwd[0][0]),
    .m0_we(mwe[0][0]), .m0_rvalid(rv[0][0]), .m0_rdata(rd[0][0]),
    .m1_valid(mv[0][1]), .m1_ready(rdy[0][1]), .m1_addr(ma[0][1]), .m1_wdata(mwd[0][1]),
    .m1_we(mwe[0][1]), .m1_rvalid(rv[0][1]), .m1_rdata(rd[0][1]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0])
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .m0_valid(mv[1][0]), .m0_ready(rdy[1][0]), .m0_addr(ma[1][0]), .m0_wdata(mwd[1][0]),
    .m0_we(mwe[1][0]), .m0_rvalid(rv[1][0]), .m0_rdata(rd[1][0]),
    .m1_valid(mv[1][1]), .m1_ready(rdy[1][1]), .m1_addr(ma[1][1]), .m1_wdata(mwd[1][1]),
    .m1_we(mwe[1][1]), .m1_rvalid(rv[1][1]), .m1_rdata(rd[1][1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1])
  );

  function automatic logic [31:0] init_word(input int k);
    return 32'hA5000000 | 32'(k);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [31:0] mem [256];
    logic [31:0] q;
    initial for (int k = 0; k < 256; k++) mem[k] = init_word(k);
    always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[g][b]) mem[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      if (mem_re[g]) q <= mem[mem_addr[g][9:2]];
    end
    assign mem_rdata[g] = q;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        mv[i][p] = 1'b0; ma[i][p] = '0; mwd[i][p] = '0; mwe[i][p] = '0;
      end
  endtask

  task automatic drive(input int i, input int p, input logic [3:0] we,
                       input logic [31:0] a, input logic [31:0] d);
    mv[i][p] = 1'b1; mwe[i][p] = we; ma[i][p] = a; mwd[i][p] = d;
  endtask

  // one cycle: check read return from the previous grant, then this cycle's grant and memory bus
  task automatic step(input int i, input int g, input string tag);
    rd_exp_t e;
    logic [31:0] a;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check({tag, "_rvalid"}, {62'd0, rv[i][1], rv[i][0]}, (e.port == 1) ? 64'd2 : 64'd1);
      check({tag, "_rdata"}, 64'(rd[i][e.port]), 64'(e.data));
    end else begin
      check({tag, "_norv"}, {62'd0, rv[i][1], rv[i][0]}, 64'd0);
    end
    check({tag, "_ready"}, {62'd0, rdy[i][1], rdy[i][0]}, (g < 0) ? 64'd0 : ((g == 1) ? 64'd2 : 64'd1));
    if (g >= 0) begin
      a = ma[i][g];
      check({tag, "_maddr"}, 64'(mem_addr[i]), 64'(a));
      check({tag, "_mwe_re"}, {59'd0, mem_we[i], mem_re[i]}, {59'd0, mwe[i][g], mwe[i][g] == 4'h0});
      if (mwe[i][g] != 4'h0) begin
        check({tag, "_mwdata"}, 64'(mem_wdata[i]), 64'(mwd[i][g]));
        ref_mem[i][a[9:2]] = mwd[i][g];
      end else begin
        e.port = g;
        e.data = ref_mem[i][a[9:2]];
        sbq.push_back(e);
      end
    end else begin
      check({tag, "_idlebus"}, {27'd0, mem_re[i], mem_we[i], mem_addr[i]}, 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 256; k++) ref_mem[i][k] = init_word(k);
    reset = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rvalid", {60'd0, rv[0][1], rv[0][0], rv[1][1], rv[1][0]}, 64'd0);
    check("rst_mem_re", {62'd0, mem_re[0], mem_re[1]}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    drive(0, 0, 4'hF, 32'h10, 32'hDEADBEEF);
    step(0, 0, "wr");
    idle_all();
    step(0, -1, "wr_idle");

    drive(0, 0, 4'h0, 32'h10, 32'h0);
    step(0, 0, "rd");
    idle_all();
    step(0, -1, "rd_ret");

    for (int c = 0; c < 9; c++) begin
      drive(0, 0, 4'h0, 32'h20 + 32'(4 * c), 32'h0);
      drive(0, 1, 4'h0, 32'h80 + 32'(4 * c), 32'h0);
      step(0, exp4[c], $sformatf("burst%0d", c));
    end
    idle_all();
    step(0, -1, "burst_end");

    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 4'h0, 32'h30 + 32'(4 * c), 32'h0);
      drive(1, 1, 4'h0, 32'hC0 + 32'(4 * c), 32'h0);
      step(1, c % 2, $sformatf("alt%0d", c));
    end
    idle_all();
    step(1, -1, "alt_end");

    for (int c = 0; c < 10; c++) begin
      drive(0, 1, 4'h0, 32'h100 + 32'(4 * c), 32'h0);
      step(0, 1, $sformatf("solo%0d", c));
    end
    drive(0, 0, 4'h0, 32'h14, 32'h0);
    step(0, 0, "yield");
    step(0, 0, "yield2");
    idle_all();
    step(0, -1, "yield_end");

    drive(0, 1, 4'h0, 32'h44, 32'h0);
    step(0, 1, "pre_rst");
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rvalid", {62'd0, rv[0][1], rv[0][0]}, 64'd0);
    sbq.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    drive(0, 0, 4'h0, 32'h18, 32'h0);
    drive(0, 1, 4'h0, 32'h1C, 32'h0);
    step(0, 0, "post_rst");
    idle_all();
    step(0, -1, "post_rst_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
